// File: rtl/sprite_anim_ctrl.sv
// Per-player sprite animation sequencer: picks IDLE/WALK/ATTACK/HURT and frame index once per video frame.
// Latency: state/frame update on the clock after a frame_tick rising edge; base_addr follows one clock later.
// Backpressure: none; attack/hit requests are latched until the next frame tick and never stall the inputs.
module sprite_anim_ctrl #(
  parameter int FRAME_WORDS = 23550,
  parameter int ADDR_W      = 18,
  parameter int HOLD_TICKS  = 4,
  parameter int IDLE_FRAMES = 2,
  parameter int WALK_FRAMES = 4,
  parameter int ATK_FRAMES  = 3,
  parameter int HURT_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_tick,
  input  logic              move_left,
  input  logic              move_right,
  input  logic              attack,
  input  logic              hit,
  output logic [ADDR_W-1:0] base_addr,
  output logic [1:0]        anim_state,
  output logic [2:0]        frame_idx,
  output logic              facing_left,
  output logic              busy,
  output logic              anim_done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WALK   = 2'd1,
    ST_ATTACK = 2'd2,
    ST_HURT   = 2'd3
  } state_e;

  // Last hold count before the frame index moves on.
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_TICKS - 1);

  // Last frame index of each animation.
  localparam logic [2:0] IDLE_LAST = 3'(IDLE_FRAMES - 1);
  localparam logic [2:0] WALK_LAST = 3'(WALK_FRAMES - 1);
  localparam logic [2:0] ATK_LAST  = 3'(ATK_FRAMES - 1);
  localparam logic [2:0] HURT_LAST = 3'(HURT_FRAMES - 1);

  // Sprite ROM slot where each animation's first frame lives.
  localparam logic [3:0] IDLE_SLOT = 4'd0;
  localparam logic [3:0] WALK_SLOT = 4'(IDLE_FRAMES);
  localparam logic [3:0] ATK_SLOT  = 4'(IDLE_FRAMES + WALK_FRAMES);
  localparam logic [3:0] HURT_SLOT = 4'(IDLE_FRAMES + WALK_FRAMES + ATK_FRAMES);

  state_e              state_q, state_d;
  logic [2:0]          frame_q, frame_d;
  logic [3:0]          hold_q, hold_d;
  logic                facing_q, facing_d;
  logic                done_q, done_d;
  logic                tick_q;
  logic                atk_pend_q, atk_pend_d;
  logic                hit_pend_q, hit_pend_d;
  logic [ADDR_W-1:0]   base_q, base_d;

  logic                tick_rise;
  logic                atk_eff;
  logic                hit_eff;
  logic                dir_one;

  // Advance results, computed for the current state regardless of whether they are used.
  state_e              adv_state;
  logic [2:0]          adv_frame;
  logic [3:0]          adv_hold;
  logic                adv_done;
  logic [2:0]          last_frame;
  logic                one_shot;

  logic [3:0]          slot_off;
  logic [4:0]          slot_sum;

  assign tick_rise = frame_tick & ~tick_q;
  assign atk_eff   = atk_pend_q | attack;
  assign hit_eff   = hit_pend_q | hit;
  assign dir_one   = move_left ^ move_right;

  // Requests are remembered until the next tick, which always clears them (clear beats a same-cycle set).
  always_comb begin
    atk_pend_d = atk_pend_q | attack;
    hit_pend_d = hit_pend_q | hit;
    if (tick_rise) begin
      atk_pend_d = 1'b0;
      hit_pend_d = 1'b0;
    end
  end

  // Per-state frame count and loop/one-shot classification.
  always_comb begin
    last_frame = IDLE_LAST;
    one_shot   = 1'b0;
    unique case (state_q)
      ST_IDLE:   last_frame = IDLE_LAST;
      ST_WALK:   last_frame = WALK_LAST;
      ST_ATTACK: begin
        last_frame = ATK_LAST;
        one_shot   = 1'b1;
      end
      ST_HURT:   begin
        last_frame = HURT_LAST;
        one_shot   = 1'b1;
      end
      default:   last_frame = IDLE_LAST;
    endcase
  end

  // Hold the frame for HOLD_TICKS ticks, then step; loops wrap, one-shots fall back to IDLE.
  always_comb begin
    adv_state = state_q;
    adv_frame = frame_q;
    adv_hold  = hold_q;
    adv_done  = 1'b0;
    if (hold_q < HOLD_LAST) begin
      adv_hold = hold_q + 4'd1;
    end else begin
      adv_hold = 4'd0;
      if (frame_q < last_frame) begin
        adv_frame = frame_q + 3'd1;
      end else if (one_shot) begin
        adv_state = ST_IDLE;
        adv_frame = 3'd0;
        adv_done  = 1'b1;
      end else begin
        adv_frame = 3'd0;
      end
    end
  end

  // Next-state decision, evaluated only on a frame tick in fixed priority order.
  always_comb begin
    state_d  = state_q;
    frame_d  = frame_q;
    hold_d   = hold_q;
    facing_d = facing_q;
    done_d   = 1'b0;
    if (tick_rise) begin
      if (hit_eff && (state_q != ST_HURT)) begin
        // Getting hit aborts anything, including an attack, without a done pulse.
        state_d = ST_HURT;
        frame_d = 3'd0;
        hold_d  = 4'd0;
      end else if ((state_q == ST_ATTACK) || (state_q == ST_HURT)) begin
        state_d = adv_state;
        frame_d = adv_frame;
        hold_d  = adv_hold;
        done_d  = adv_done;
      end else if (atk_eff) begin
        state_d = ST_ATTACK;
        frame_d = 3'd0;
        hold_d  = 4'd0;
      end else if (dir_one && (state_q == ST_WALK)) begin
        state_d = adv_state;
        frame_d = adv_frame;
        hold_d  = adv_hold;
      end else if (dir_one) begin
        state_d = ST_WALK;
        frame_d = 3'd0;
        hold_d  = 4'd0;
      end else if (state_q == ST_WALK) begin
        state_d = ST_IDLE;
        frame_d = 3'd0;
        hold_d  = 4'd0;
      end else begin
        state_d = adv_state;
        frame_d = adv_frame;
        hold_d  = adv_hold;
      end
      // Facing only follows the stick while the player is free to move.
      if (((state_d == ST_IDLE) || (state_d == ST_WALK)) && dir_one) begin
        facing_d = move_left;
      end
    end
  end

  // ROM slot of the currently registered state; the address is registered from it.
  always_comb begin
    slot_off = IDLE_SLOT;
    unique case (state_q)
      ST_IDLE:   slot_off = IDLE_SLOT;
      ST_WALK:   slot_off = WALK_SLOT;
      ST_ATTACK: slot_off = ATK_SLOT;
      ST_HURT:   slot_off = HURT_SLOT;
      default:   slot_off = IDLE_SLOT;
    endcase
    slot_sum = {1'b0, slot_off} + {2'b00, frame_q};
    base_d   = ADDR_W'(32'(slot_sum) * 32'(FRAME_WORDS));
  end

  // State register; tick_q resets high so a tick already asserted at reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      frame_q    <= 3'd0;
      hold_q     <= 4'd0;
      facing_q   <= 1'b0;
      done_q     <= 1'b0;
      tick_q     <= 1'b1;
      atk_pend_q <= 1'b0;
      hit_pend_q <= 1'b0;
      base_q     <= '0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      hold_q     <= hold_d;
      facing_q   <= facing_d;
      done_q     <= done_d;
      tick_q     <= frame_tick;
      atk_pend_q <= atk_pend_d;
      hit_pend_q <= hit_pend_d;
      base_q     <= base_d;
    end
  end

  assign base_addr   = base_q;
  assign anim_state  = state_q;
  assign frame_idx   = frame_q;
  assign facing_left = facing_q;
  assign busy        = (state_q == ST_ATTACK) || (state_q == ST_HURT);
  assign anim_done   = done_q;

endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Directed bench for sprite_anim_ctrl with default parameters (HOLD_TICKS=4, frames 2/4/3/2).
// Inputs change on the falling clock edge; outputs are sampled on falling edges too.
// anim_done pulses are counted on rising edges so a stuck-high done is visible.
module tb_sprite_anim_ctrl;

  logic        clk;
  logic        rst_n;
  logic        frame_tick;
  logic        move_left;
  logic        move_right;
  logic        attack;
  logic        hit;
  logic [17:0] base_addr;
  logic [1:0]  anim_state;
  logic [2:0]  frame_idx;
  logic        facing_left;
  logic        busy;
  logic        anim_done;

  int checks;
  int failures;
  int done_pulses;

  sprite_anim_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .move_left  (move_left),
    .move_right (move_right),
    .attack     (attack),
    .hit        (hit),
    .base_addr  (base_addr),
    .anim_state (anim_state),
    .frame_idx  (frame_idx),
    .facing_left(facing_left),
    .busy       (busy),
    .anim_done  (anim_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (anim_done === 1'b1) done_pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // One frame tick; returns on the falling edge right after the update clock.
  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic pulse(input logic do_atk, input logic do_hit);
    @(negedge clk);
    attack = do_atk;
    hit    = do_hit;
    @(negedge clk);
    attack = 1'b0;
    hit    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frame_tick = 1'b1;
    move_left = 1'b0; move_right = 1'b0; attack = 1'b0; hit = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (base_addr !== 18'd0) begin failures++; $display("FAIL rst_base: got %0d expected 0", base_addr); end
    checks++; if (anim_state !== 2'd0) begin failures++; $display("FAIL rst_state: got %0d expected 0", anim_state); end
    checks++; if (frame_idx !== 3'd0) begin failures++; $display("FAIL rst_frame: got %0d expected 0", frame_idx); end
    checks++; if ({facing_left, busy, anim_done} !== 3'b000) begin failures++; $display("FAIL rst_flags: got %b expected 000", {facing_left, busy, anim_done}); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({anim_state, frame_idx} !== 5'd0) begin failures++; $display("FAIL rst_tick_high: got %b expected 00000", {anim_state, frame_idx}); end
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  // With frame_tick high through reset release, the first real edge is the first tick below.
  task automatic test_idle_loop();
    for (int t = 1; t <= 8; t++) begin
      tick();
      @(negedge clk);
      if (t == 3) begin
        checks++; if (frame_idx !== 3'd0) begin failures++; $display("FAIL idle_t3_frame: got %0d expected 0", frame_idx); end
      end
      if (t == 4) begin
        checks++; if (frame_idx !== 3'd1) begin failures++; $display("FAIL idle_t4_frame: got %0d expected 1", frame_idx); end
        checks++; if (base_addr !== 18'd23550) begin failures++; $display("FAIL idle_t4_base: got %0d expected 23550", base_addr); end
      end
      if (t == 7) begin
        checks++; if (frame_idx !== 3'd1) begin failures++; $display("FAIL idle_t7_frame: got %0d expected 1", frame_idx); end
      end
      if (t == 8) begin
        checks++; if ({anim_state, frame_idx} !== 5'd0) begin failures++; $display("FAIL idle_wrap: got %b expected 00000", {anim_state, frame_idx}); end
        checks++; if (base_addr !== 18'd0) begin failures++; $display("FAIL idle_wrap_base: got %0d expected 0", base_addr); end
      end
    end
  endtask

  task automatic test_walk();
    move_right = 1'b1;
    tick();
    checks++; if (anim_state !== 2'd1 || facing_left !== 1'b0) begin failures++; $display("FAIL walk_right: got state %0d facing %b expected 1/0", anim_state, facing_left); end
    move_right = 1'b0;
    tick();
    checks++; if (anim_state !== 2'd0) begin failures++; $display("FAIL walk_release: got %0d expected 0", anim_state); end
    move_left = 1'b1;
    tick();
    checks++; if (anim_state !== 2'd1 || frame_idx !== 3'd0 || facing_left !== 1'b1) begin failures++; $display("FAIL walk_left: got state %0d frame %0d facing %b expected 1/0/1", anim_state, frame_idx, facing_left); end
    checks++; if (base_addr !== 18'd0) begin failures++; $display("FAIL walk_base_latency: got %0d expected 0", base_addr); end
    @(negedge clk);
    checks++; if (base_addr !== 18'd47100) begin failures++; $display("FAIL walk_base: got %0d expected 47100", base_addr); end
    tick();
    move_right = 1'b1;
    tick();
    checks++; if (anim_state !== 2'd0 || frame_idx !== 3'd0 || facing_left !== 1'b1) begin failures++; $display("FAIL walk_both: got state %0d frame %0d facing %b expected 0/0/1", anim_state, frame_idx, facing_left); end
    move_left = 1'b0;
    move_right = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_attack();
    int d0;
    pulse(1'b1, 1'b0);
    tick();
    @(negedge clk);
    checks++; if (anim_state !== 2'd2 || frame_idx !== 3'd0 || busy !== 1'b1) begin failures++; $display("FAIL atk_enter: got state %0d frame %0d busy %b expected 2/0/1", anim_state, frame_idx, busy); end
    checks++; if (base_addr !== 18'd141300) begin failures++; $display("FAIL atk_base: got %0d expected 141300", base_addr); end
    d0 = done_pulses;
    move_right = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    move_right = 1'b0;
    checks++; if (anim_state !== 2'd2 || frame_idx !== 3'd2 || facing_left !== 1'b1) begin failures++; $display("FAIL atk_t11: got state %0d frame %0d facing %b expected 2/2/1", anim_state, frame_idx, facing_left); end
    checks++; if (done_pulses !== d0) begin failures++; $display("FAIL atk_early_done: got %0d pulses expected 0", done_pulses - d0); end
    tick();
    checks++; if (anim_state !== 2'd0 || busy !== 1'b0 || anim_done !== 1'b1) begin failures++; $display("FAIL atk_exit: got state %0d busy %b done %b expected 0/0/1", anim_state, busy, anim_done); end
    @(negedge clk);
    checks++; if (anim_done !== 1'b0 || done_pulses - d0 !== 1) begin failures++; $display("FAIL atk_done_pulse: got done %b pulses %0d expected 0/1", anim_done, done_pulses - d0); end
  endtask

  task automatic test_hurt();
    int d0;
    pulse(1'b1, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) tick();
    @(negedge clk);
    checks++; if (anim_state !== 2'd2 || frame_idx !== 3'd1) begin failures++; $display("FAIL hurt_pre: got state %0d frame %0d expected 2/1", anim_state, frame_idx); end
    d0 = done_pulses;
    pulse(1'b0, 1'b1);
    tick();
    @(negedge clk);
    checks++; if (anim_state !== 2'd3 || frame_idx !== 3'd0 || busy !== 1'b1) begin failures++; $display("FAIL hurt_enter: got state %0d frame %0d busy %b expected 3/0/1", anim_state, frame_idx, busy); end
    checks++; if (base_addr !== 18'd211950) begin failures++; $display("FAIL hurt_base: got %0d expected 211950", base_addr); end
    for (int i = 0; i < 7; i++) begin
      pulse(1'b1, 1'b1);
      tick();
    end
    checks++; if (anim_state !== 2'd3 || frame_idx !== 3'd1) begin failures++; $display("FAIL hurt_t7: got state %0d frame %0d expected 3/1", anim_state, frame_idx); end
    checks++; if (done_pulses !== d0) begin failures++; $display("FAIL hurt_abort_done: got %0d pulses expected 0", done_pulses - d0); end
    pulse(1'b1, 1'b0);
    tick();
    checks++; if (anim_state !== 2'd0 || anim_done !== 1'b1) begin failures++; $display("FAIL hurt_exit: got state %0d done %b expected 0/1", anim_state, anim_done); end
    @(negedge clk);
    checks++; if (done_pulses - d0 !== 1) begin failures++; $display("FAIL hurt_done_count: got %0d expected 1", done_pulses - d0); end
    tick();
    checks++; if (anim_state !== 2'd0) begin failures++; $display("FAIL hurt_discard: got %0d expected 0", anim_state); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    frame_tick = 1'b1;
    hit = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    hit = 1'b0;
    checks++; if (anim_state !== 2'd3) begin failures++; $display("FAIL same_cycle_hit: got %0d expected 3", anim_state); end
    tick();
    pulse(1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({anim_state, frame_idx, facing_left, busy, anim_done} !== 8'd0) begin failures++; $display("FAIL async_rst: got %b expected 00000000", {anim_state, frame_idx, facing_left, busy, anim_done}); end
    checks++; if (base_addr !== 18'd0) begin failures++; $display("FAIL async_rst_base: got %0d expected 0", base_addr); end
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    checks++; if (anim_state !== 2'd0) begin failures++; $display("FAIL rst_pend_clear: got %0d expected 0", anim_state); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    done_pulses = 0;
    test_reset();
    test_idle_loop();
    test_walk();
    test_attack();
    test_hurt();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_anim_ctrl.md
Name: sprite_anim_ctrl

Overview:
- Per-player animation sequencer for the sprite-ROM pixel path.
- Picks the animation state (idle, walk, attack, hurt) and the frame index from player inputs, once per video frame.
- Outputs the ROM base address of the current frame plus the facing flag; the sprite renderer adds its pixel offset to that base.
- State and frame change only on a frame_tick rising edge, so a sprite never tears mid-frame.

Parameters:
- FRAME_WORDS, 23550: words per sprite frame (150x157).
- ADDR_W, 18: base_addr width.
- HOLD_TICKS, 4: frame ticks each animation frame is held, 1..15.
- IDLE_FRAMES, 2: frames in IDLE; slot offset 0.
- WALK_FRAMES, 4: frames in WALK; slot offset IDLE_FRAMES.
- ATK_FRAMES, 3: frames in ATTACK; slot offset IDLE_FRAMES+WALK_FRAMES.
- HURT_FRAMES, 2: frames in HURT; slot offset IDLE+WALK+ATK.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  vsync-derived level; its rising edge is the update point.
- move_left  in  1  level input.
- move_right  in  1  level input.
- attack  in  1  pulse or level; latched.
- hit  in  1  pulse or level; latched.
- base_addr  out  ADDR_W  ROM address of the current frame's first word.
- anim_state  out  2  0=IDLE, 1=WALK, 2=ATTACK, 3=HURT.
- frame_idx  out  3  frame within the current state.
- facing_left  out  1  1 = draw mirrored.
- busy  out  1  high in ATTACK or HURT.
- anim_done  out  1  one-cycle pulse when a one-shot animation completes.

Behaviour:
- Reset (rst_n low, async):
  - anim_state=IDLE, frame_idx=0, hold_cnt=0, facing_left=0.
  - base_addr=0, busy=0, anim_done=0.
  - atk_pend=0, hit_pend=0.
  - tick_d=1, so a frame_tick already high at reset release produces no edge.
- Edge detect: tick_rise = frame_tick & ~tick_d; tick_d is frame_tick registered.
- Pending latches:
  - Any cycle with attack high sets atk_pend; any cycle with hit high sets hit_pend.
  - Effective requests: atk_eff = atk_pend|attack, hit_eff = hit_pend|hit.
  - Both latches clear on every tick_rise cycle, whether the request was consumed or discarded. Clear wins over set in that cycle.
- On cycles without tick_rise: state, frame_idx, hold_cnt and facing_left hold.
- On tick_rise, evaluate in priority order:
  1. hit_eff and state!=HURT: go to HURT, frame 0, hold 0. This aborts ATTACK with no anim_done.
  2. State HURT or ATTACK: advance (see below). New attack or hit requests are ignored, except rule 1 for ATTACK.
  3. atk_eff (state IDLE or WALK): go to ATTACK, frame 0, hold 0.
  4. Exactly one of left/right, and state WALK: advance.
  5. Exactly one of left/right, and state IDLE: go to WALK, frame 0, hold 0.
  6. Otherwise (none or both of left/right):
     - state WALK: go to IDLE, frame 0, hold 0;
     - state IDLE: advance.
- Facing: facing_left updates on tick_rise only when the resulting state is IDLE or WALK and exactly one direction is held (left sets 1, right sets 0). Frozen in ATTACK and HURT.
- Advance:
  - If hold_cnt < HOLD_TICKS-1: hold_cnt+1.
  - Else hold_cnt=0 and frame_idx+1.
  - When a looping state (IDLE, WALK) passes its last frame, frame_idx wraps to 0.
  - When a one-shot state (ATTACK, HURT) passes its last frame, it goes to IDLE, frame 0, and anim_done=1 for exactly one cycle, registered together with that transition.
- base_addr: registered, one clock after anim_state/frame_idx. Value = (slot_offset(state)+frame_idx)*FRAME_WORDS, truncated to ADDR_W. Max slot 10 gives 235500, which fits 18 bits.
- busy: decoded from registered state (no added latency).
- Request arriving in the same cycle as tick_rise: used in that evaluation.

Test Plan:
- Reset with frame_tick held high, release rst_n -> no state change until frame_tick falls and rises again; all outputs 0.
- No inputs, HOLD_TICKS=4, 8 ticks -> IDLE frame 0 for 4 ticks, then frame 1, then wrap to 0 at tick 8; base_addr 0 -> 23550 -> 0.
- move_left held -> next tick: WALK frame 0, facing_left=1, base_addr=47100 one cycle later. Then left and right both held -> next tick: IDLE, frame 0, facing unchanged.
- One-cycle attack pulse between ticks -> next tick: ATTACK frame 0, busy=1. After 12 ticks: IDLE, anim_done pulses exactly one cycle, busy=0.
- hit pulse during ATTACK frame 1 -> next tick: HURT frame 0 (base_addr=211950), no anim_done. Further hit pulses during HURT are ignored; anim_done fires after 8 ticks.
- Assert rst_n low mid-HURT -> outputs go to reset values immediately (async), and pending latches are cleared.
